// File: rtl/cdb_arbiter_pkg.sv
// cdb_arbiter_pkg: shared types and constants for the common data bus arbiter.
// Provides the ROB id, data and address types, zero constants, boolean and
// CDB source encodings, and the 70-bit FIFO payload struct.
package cdb_arbiter_pkg;
  typedef logic [4:0]  rob_id_t;
  typedef logic [31:0] data_t;
  typedef logic [31:0] addr_t;
  localparam rob_id_t ZERO_ROB    = '0;
  localparam data_t   ZERO_WORD   = '0;
  localparam addr_t   ZERO_ADDR   = '0;
  localparam logic    TRUE        = 1'b1;
  localparam logic    FALSE       = 1'b0;
  localparam logic    CDB_SRC_ALU = 1'b0;
  localparam logic    CDB_SRC_LSU = 1'b1;
  typedef struct packed {
    rob_id_t rob_id;
    data_t   value;
    addr_t   target_pc;
    logic    jump_flag;
  } cdb_entry_t;
endpackage

// File: rtl/cdb_src_fifo.sv
// cdb_src_fifo: per-source result FIFO feeding the CDB arbiter.
// Ports: clk, rst (async active-low), rdy (freeze when low), flush (empty all),
// push/push_data (write at tail), pop (advance head), full/empty/head.
// DEPTH must be a power of two so pointers wrap naturally and full is the
// count MSB.
module cdb_src_fifo
  import cdb_arbiter_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int PTR_W = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rdy,
  input  logic       flush,
  input  logic       push,
  input  logic       pop,
  input  cdb_entry_t push_data,
  output logic       full,
  output logic       empty,
  output cdb_entry_t head
);
  cdb_entry_t       mem_q [DEPTH];
  logic [PTR_W-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [PTR_W:0]   cnt_q, cnt_d;
  always_comb begin
    wr_d  = flush ? '0 : wr_q + PTR_W'(push);
    rd_d  = flush ? '0 : rd_q + PTR_W'(pop);
    cnt_d = flush ? '0 : cnt_q + {{PTR_W{1'b0}}, push} - {{PTR_W{1'b0}}, pop};
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else if (rdy) begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end
  always_ff @(posedge clk) begin
    if (rdy && !flush && push) mem_q[wr_q] <= push_data;
  end
  assign full  = cnt_q[PTR_W];
  assign empty = (cnt_q == '0);
  assign head  = mem_q[rd_q];
endmodule

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: round-robin single-writer arbiter for the common data bus.
// Ports: clk, rst (async active-low), rdy (freeze), flush (misbranch);
// ALU and LSU result inputs with valid/ready; registered cdb_* broadcast.
// Optional macro CDB_BYPASS_EN: a winning input whose FIFO is empty is
// loaded straight into the CDB register instead of being queued.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int FIFO_DEPTH = 2,
  parameter int PTR_W      = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        flush,
  input  logic        alu_valid,
  input  logic [4:0]  alu_rob_id,
  input  logic [31:0] alu_result,
  input  logic [31:0] alu_target_pc,
  input  logic        alu_jump_flag,
  output logic        alu_ready,
  input  logic        lsu_valid,
  input  logic [4:0]  lsu_rob_id,
  input  logic [31:0] lsu_result,
  output logic        lsu_ready,
  output logic        cdb_valid,
  output logic        cdb_src,
  output logic [4:0]  cdb_rob_id,
  output logic [31:0] cdb_value,
  output logic [31:0] cdb_target_pc,
  output logic        cdb_jump_flag
);
  cdb_entry_t alu_in, lsu_in, alu_head, lsu_head, win, cdb_q;
  logic adv, alu_full, alu_empty, lsu_full, lsu_empty;
  logic alu_ok, lsu_ok, alu_byp, lsu_byp, alu_req, lsu_req;
  logic gnt_alu, gnt_lsu, alu_push, lsu_push, alu_pop, lsu_pop, fire;
  logic last_q, valid_q, src_q;
  always_comb begin
    adv    = rdy & ~flush;
    alu_in = '{alu_rob_id, alu_result, alu_target_pc, alu_jump_flag};
    lsu_in = '{lsu_rob_id, lsu_result, ZERO_ADDR, FALSE};
    alu_ok = adv & alu_valid & ~alu_full & (alu_rob_id != ZERO_ROB);
    lsu_ok = adv & lsu_valid & ~lsu_full & (lsu_rob_id != ZERO_ROB);
`ifdef CDB_BYPASS_EN
    alu_byp = alu_ok & alu_empty;
    lsu_byp = lsu_ok & lsu_empty;
`else
    alu_byp = FALSE;
    lsu_byp = FALSE;
`endif
    // A bypass candidate competes as if it were already the FIFO head.
    alu_req  = ~alu_empty | alu_byp;
    lsu_req  = ~lsu_empty | lsu_byp;
    gnt_alu  = alu_req & (~lsu_req | (last_q == CDB_SRC_LSU));
    gnt_lsu  = lsu_req & ~gnt_alu;
    fire     = adv & (gnt_alu | gnt_lsu);
    alu_pop  = adv & gnt_alu & ~alu_empty;
    lsu_pop  = adv & gnt_lsu & ~lsu_empty;
    // A granted input with an empty FIFO was bypassed, so it is not queued.
    alu_push = alu_ok & ~(gnt_alu & alu_empty);
    lsu_push = lsu_ok & ~(gnt_lsu & lsu_empty);
    win      = gnt_alu ? (alu_empty ? alu_in : alu_head) : (lsu_empty ? lsu_in : lsu_head);
  end
  cdb_src_fifo #(.DEPTH(FIFO_DEPTH), .PTR_W(PTR_W)) u_alu_fifo (
    .clk(clk), .rst(rst), .rdy(rdy), .flush(flush), .push(alu_push), .pop(alu_pop),
    .push_data(alu_in), .full(alu_full), .empty(alu_empty), .head(alu_head)
  );
  cdb_src_fifo #(.DEPTH(FIFO_DEPTH), .PTR_W(PTR_W)) u_lsu_fifo (
    .clk(clk), .rst(rst), .rdy(rdy), .flush(flush), .push(lsu_push), .pop(lsu_pop),
    .push_data(lsu_in), .full(lsu_full), .empty(lsu_empty), .head(lsu_head)
  );
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= FALSE;
      src_q   <= CDB_SRC_ALU;
      cdb_q   <= '0;
      last_q  <= CDB_SRC_LSU;
    end else if (rdy) begin
      valid_q <= fire;
      if (fire) begin
        src_q  <= gnt_lsu ? CDB_SRC_LSU : CDB_SRC_ALU;
        last_q <= gnt_lsu ? CDB_SRC_LSU : CDB_SRC_ALU;
        cdb_q  <= win;
      end
    end
  end
  assign alu_ready     = ~alu_full;
  assign lsu_ready     = ~lsu_full;
  assign cdb_valid     = valid_q;
  assign cdb_src       = src_q;
  assign cdb_rob_id    = cdb_q.rob_id;
  assign cdb_value     = cdb_q.value;
  assign cdb_target_pc = cdb_q.target_pc;
  assign cdb_jump_flag = cdb_q.jump_flag;
endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: directed self-checking bench for cdb_arbiter (default build).
module tb_cdb_arbiter;
  logic        clk = 1'b0, rst = 1'b0, rdy = 1'b1, flush = 1'b0;
  logic        alu_valid, alu_jump_flag, alu_ready, lsu_valid, lsu_ready;
  logic [4:0]  alu_rob_id, lsu_rob_id, cdb_rob_id;
  logic [31:0] alu_result, alu_target_pc, lsu_result, cdb_value, cdb_target_pc;
  logic        cdb_valid, cdb_src, cdb_jump_flag;
  int vecs = 0, errs = 0;
  int got[$];
  cdb_arbiter dut (
    .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
    .alu_valid(alu_valid), .alu_rob_id(alu_rob_id), .alu_result(alu_result),
    .alu_target_pc(alu_target_pc), .alu_jump_flag(alu_jump_flag), .alu_ready(alu_ready),
    .lsu_valid(lsu_valid), .lsu_rob_id(lsu_rob_id), .lsu_result(lsu_result), .lsu_ready(lsu_ready),
    .cdb_valid(cdb_valid), .cdb_src(cdb_src), .cdb_rob_id(cdb_rob_id), .cdb_value(cdb_value),
    .cdb_target_pc(cdb_target_pc), .cdb_jump_flag(cdb_jump_flag)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic tick_rec();
    tick();
    if (cdb_valid) got.push_back(int'(cdb_rob_id));
  endtask
  task automatic alu(input logic v, input logic [4:0] id, input logic [31:0] r = 32'h0,
                     input logic [31:0] t = 32'h0, input logic j = 1'b0);
    alu_valid = v; alu_rob_id = id; alu_result = r; alu_target_pc = t; alu_jump_flag = j;
  endtask
  task automatic lsu(input logic v, input logic [4:0] id, input logic [31:0] r = 32'h0);
    lsu_valid = v; lsu_rob_id = id; lsu_result = r;
  endtask
  task automatic idle();
    alu(1'b0, 5'd0);
    lsu(1'b0, 5'd0);
  endtask
  task automatic pulse_reset();
    rst = 1'b0;
    #1 rst = 1'b1;
  endtask
  task automatic expect_cdb(input string tag, input logic src, input logic [4:0] id);
    check({tag, "_valid"}, cdb_valid, 1);
    check({tag, "_src"}, cdb_src, src);
    check({tag, "_id"}, cdb_rob_id, id);
  endtask
  task automatic check_order(input string tag, input int exp[$]);
    check({tag, "_count"}, got.size(), exp.size());
    for (int i = 0; i < exp.size(); i++)
      check(tag, (i < got.size()) ? got[i] : -1, exp[i]);
  endtask
  initial begin
    idle();
    #3;
    check("rst_valid", cdb_valid, 0);
    check("rst_src", cdb_src, 0);
    check("rst_id", cdb_rob_id, 0);
    check("rst_value", cdb_value, 0);
    check("rst_target", cdb_target_pc, 0);
    check("rst_jump", cdb_jump_flag, 0);
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("rst_alu_ready", alu_ready, 1);
    check("rst_lsu_ready", lsu_ready, 1);
    // single ALU result: one cycle of visible delay
    alu(1, 3, 32'h11, 32'h104, 1);
    tick();
    idle();
    check("single_early", cdb_valid, 0);
    tick();
    expect_cdb("single", 0, 3);
    check("single_value", cdb_value, 32'h11);
    check("single_target", cdb_target_pc, 32'h104);
    check("single_jump", cdb_jump_flag, 1);
    tick();
    check("single_drop", cdb_valid, 0);
    check("single_hold", cdb_value, 32'h11);
    // same-edge tie after reset goes to the ALU
    pulse_reset();
    alu(1, 2, 32'h22, 32'h200, 1);
    lsu(1, 5, 32'h55);
    tick();
    idle();
    tick();
    expect_cdb("tie_first", 0, 2);
    check("tie_first_value", cdb_value, 32'h22);
    tick();
    expect_cdb("tie_second", 1, 5);
    check("tie_lsu_value", cdb_value, 32'h55);
    check("tie_lsu_target", cdb_target_pc, 0);
    check("tie_lsu_jump", cdb_jump_flag, 0);
    tick();
    check("tie_idle", cdb_valid, 0);
    // both saturated: producers hold data until accepted
    got.delete();
    begin
      int na = 0, nl = 0;
      for (int c = 0; c < 20; c++) begin
        logic a_acc, l_acc;
        alu(na < 4, 5'(na + 1), 32'(na + 1));
        lsu(nl < 4, 5'(nl + 9), 32'(nl + 9));
        a_acc = alu_valid && alu_ready;
        l_acc = lsu_valid && lsu_ready;
        tick_rec();
        if (a_acc) na++;
        if (l_acc) nl++;
      end
    end
    idle();
    check_order("sat_order", '{1, 9, 2, 10, 3, 11, 4, 12});
    // LSU backpressure: third LSU result offered while full is dropped
    pulse_reset();
    got.delete();
    alu(1, 1); lsu(1, 6); tick_rec();
    alu(1, 2); lsu(1, 7); tick_rec();
    check("bp_lsu_ready", lsu_ready, 0);
    alu(1, 3); lsu(1, 8); tick_rec();
    idle();
    repeat (5) tick_rec();
    check_order("bp_order", '{1, 6, 2, 7, 3});
    // flush with two ALU and one LSU entry buffered plus a new ALU result
    pulse_reset();
    got.delete();
    alu(1, 1); lsu(1, 9); tick_rec();
    alu(1, 2); lsu(0, 0); tick_rec();
    alu(0, 0); lsu(1, 10); tick_rec();
    alu(1, 3); lsu(0, 0); tick_rec();
    alu(1, 4); lsu(1, 11); tick_rec();
    check("fl_pre_alu_full", alu_ready, 0);
    check_order("fl_pre_order", '{1, 9, 2, 10});
    alu(1, 6); lsu(0, 0); flush = 1'b1;
    tick();
    flush = 1'b0;
    idle();
    check("fl_valid", cdb_valid, 0);
    check("fl_alu_ready", alu_ready, 1);
    check("fl_lsu_ready", lsu_ready, 1);
    got.delete();
    repeat (3) tick_rec();
    check("fl_no_stale", got.size(), 0);
    alu(1, 7); lsu(1, 12); tick();
    idle();
    tick();
    expect_cdb("fl_after_first", 0, 7);
    tick();
    expect_cdb("fl_after_second", 1, 12);
    // rdy low freezes everything, including flush and pushes
    pulse_reset();
    alu(1, 7); lsu(1, 13); tick();
    alu(1, 8); lsu(1, 14); tick();
    expect_cdb("frz_pre", 0, 7);
    rdy = 1'b0;
    alu(1, 9); lsu(0, 0); flush = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      expect_cdb("frz_hold", 0, 7);
      check("frz_lsu_ready", lsu_ready, 0);
      check("frz_alu_ready", alu_ready, 1);
    end
    rdy = 1'b1;
    flush = 1'b0;
    alu(1, 0, 32'hbad);
    tick();
    idle();
    expect_cdb("frz_resume1", 1, 13);
    tick();
    expect_cdb("frz_resume2", 0, 8);
    tick();
    expect_cdb("frz_resume3", 1, 14);
    tick();
    check("frz_zero_id_dropped", cdb_valid, 0);
    tick();
    check("frz_zero_id_dropped2", cdb_valid, 0);
    // asynchronous reset while both FIFOs hold entries
    alu(1, 1); lsu(1, 2); tick();
    alu(1, 3); lsu(1, 4); tick();
    idle();
    expect_cdb("mid_pre", 0, 1);
    #1 rst = 1'b0;
    #1;
    check("mid_async_valid", cdb_valid, 0);
    check("mid_async_id", cdb_rob_id, 0);
    check("mid_async_value", cdb_value, 0);
    rst = 1'b1;
    #1;
    check("mid_alu_ready", alu_ready, 1);
    check("mid_lsu_ready", lsu_ready, 1);
    tick();
    check("mid_empty1", cdb_valid, 0);
    tick();
    check("mid_empty2", cdb_valid, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
